// File: rtl/vector_alu.sv
// Registered 64-bit SIMD ALU for R-type vector instructions.
// Lane 0 is the MSB lane; ports use [0:63] numbering with bit 0 as the MSB.

module vector_alu_lanes #(
  parameter int W = 8
) (
  input  logic [5:0]  func,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] res
);
  localparam int N  = 64 / W;
  localparam int SW = $clog2(W);

  localparam logic [5:0] F_VADD   = 6'b000110;
  localparam logic [5:0] F_VSUB   = 6'b000111;
  localparam logic [5:0] F_VMULEU = 6'b001000;
  localparam logic [5:0] F_VMULOU = 6'b001001;
  localparam logic [5:0] F_VSLL   = 6'b001010;
  localparam logic [5:0] F_VSRL   = 6'b001011;
  localparam logic [5:0] F_VSRA   = 6'b001100;
  localparam logic [5:0] F_VRTTH  = 6'b001101;
  localparam logic [5:0] F_VDIV   = 6'b001110;
  localparam logic [5:0] F_VMOD   = 6'b001111;
  localparam logic [5:0] F_VSQEU  = 6'b010000;
  localparam logic [5:0] F_VSQOU  = 6'b010001;
  localparam logic [5:0] F_VSQRT  = 6'b010010;

  logic [W-1:0]  al, bl, rl;
  logic [SW-1:0] sh;
  logic [63:0]   prod;
  int            lo;
  logic          odd, square;

  // Bit-by-bit integer square root; the trial value never exceeds W/2 bits
  function automatic logic [W-1:0] isqrt(input logic [W-1:0] x);
    logic [W-1:0] r, t;
    r = '0;
    for (int k = W/2 - 1; k >= 0; k--) begin
      t = r;
      t[k] = 1'b1;
      if (t * t <= x) r = t;
    end
    return r;
  endfunction

  always_comb begin
    res    = '0;
    prod   = '0;
    al     = '0;
    bl     = '0;
    rl     = '0;
    sh     = '0;
    lo     = 0;
    odd    = (func == F_VMULOU) || (func == F_VSQOU);
    square = (func == F_VSQEU) || (func == F_VSQOU);
    case (func)
      F_VMULEU, F_VMULOU, F_VSQEU, F_VSQOU: begin
        // Double-width product of the chosen lane lands across its even/odd pair
        for (int k = 0; k < N/2; k++) begin
          lo   = 64 - (2*k + 1 + int'(odd)) * W;
          al   = a[lo +: W];
          bl   = square ? al : b[lo +: W];
          prod = 64'(al) * 64'(bl);
          res  = res | (prod << (64 - (2*k + 2) * W));
        end
      end
      default: begin
        for (int i = 0; i < N; i++) begin
          lo = 64 - (i + 1) * W;
          al = a[lo +: W];
          bl = b[lo +: W];
          sh = bl[SW-1:0];
          case (func)
            F_VADD:  rl = al + bl;
            F_VSUB:  rl = al - bl;
            F_VSLL:  rl = al << sh;
            F_VSRL:  rl = al >> sh;
            F_VSRA:  rl = $signed(al) >>> sh;
            F_VRTTH: rl = {al[W/2-1:0], al[W-1:W/2]};
            F_VDIV:  rl = (bl == '0) ? '1 : al / bl;
            F_VMOD:  rl = (bl == '0) ? al : al % bl;
            F_VSQRT: rl = isqrt(al);
            default: rl = '0;
          endcase
          res[lo +: W] = rl;
        end
      end
    endcase
  end
endmodule

module vector_alu (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:63] rA_64bit_val,
  input  logic [0:63] rB_64bit_val,
  input  logic [5:0]  R_ins,
  input  logic [5:0]  Op_code,
  input  logic [1:0]  WW,
  output logic [0:63] ALU_out
);
  localparam logic [5:0] OPC_RTYPE = 6'b101010;

  localparam logic [5:0] F_VAND = 6'b000001;
  localparam logic [5:0] F_VOR  = 6'b000010;
  localparam logic [5:0] F_VXOR = 6'b000011;
  localparam logic [5:0] F_VNOT = 6'b000100;
  localparam logic [5:0] F_VMOV = 6'b000101;

  logic [63:0] a, b, next_val;
  logic [63:0] res8, res16, res32, res64;

  assign a = rA_64bit_val;
  assign b = rB_64bit_val;

  vector_alu_lanes #(.W(8))  lanes8  (.func(R_ins), .a(a), .b(b), .res(res8));
  vector_alu_lanes #(.W(16)) lanes16 (.func(R_ins), .a(a), .b(b), .res(res16));
  vector_alu_lanes #(.W(32)) lanes32 (.func(R_ins), .a(a), .b(b), .res(res32));
  vector_alu_lanes #(.W(64)) lanes64 (.func(R_ins), .a(a), .b(b), .res(res64));

  // The 64-bit lane unit yields zero for multiply/square, as there is no pair to fill
  always_comb begin
    next_val = '0;
    if (Op_code == OPC_RTYPE) begin
      case (R_ins)
        F_VAND:  next_val = a & b;
        F_VOR:   next_val = a | b;
        F_VXOR:  next_val = a ^ b;
        F_VNOT:  next_val = ~a;
        F_VMOV:  next_val = a;
        default: begin
          case (WW)
            2'b00:   next_val = res8;
            2'b01:   next_val = res16;
            2'b10:   next_val = res32;
            default: next_val = res64;
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ALU_out <= '0;
    else       ALU_out <= next_val;
  end
endmodule

// File: tb/tb_vector_alu.sv
// Self-checking bench for vector_alu: directed vectors plus randomized ops
// compared against a lane-arithmetic reference model.

module tb_vector_alu;
  localparam logic [5:0] RTYPE = 6'b101010;

  logic        clk = 1'b0;
  logic        reset;
  logic [0:63] aVal, bVal;
  logic [5:0]  rIns, opCode;
  logic [1:0]  ww;
  logic [0:63] aluOut;

  int assertCount = 0;
  int failCount = 0;

  logic [5:0] opList [19] = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9,
                              6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15, 6'd16, 6'd17,
                              6'd18, 6'd63};

  vector_alu dut (
    .clk(clk), .reset(reset), .rA_64bit_val(aVal), .rB_64bit_val(bVal),
    .R_ins(rIns), .Op_code(opCode), .WW(ww), .ALU_out(aluOut)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] intSqrt(input logic [63:0] x);
    logic [63:0] lo, hi, mid;
    lo = 0;
    hi = 64'hFFFF_FFFF;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= x) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  function automatic logic [63:0] refModel(input logic [5:0] op, input logic [5:0] f,
                                           input logic [1:0] wsel, input logic [63:0] a,
                                           input logic [63:0] b);
    int w, n, pos, e, s;
    logic [63:0] mask, la, lb, r, res;
    res = 0;
    if (op != RTYPE) return 0;
    w = 8 << wsel;
    n = 64 / w;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 1);
    case (f)
      6'd1: return a & b;
      6'd2: return a | b;
      6'd3: return a ^ b;
      6'd4: return ~a;
      6'd5: return a;
      6'd8, 6'd9, 6'd16, 6'd17: begin
        if (w == 64) return 0;
        for (int k = 0; k < n/2; k++) begin
          e = 2*k + ((f == 6'd9 || f == 6'd17) ? 1 : 0);
          la = (a >> (64 - (e + 1) * w)) & mask;
          lb = (f >= 6'd16) ? la : ((b >> (64 - (e + 1) * w)) & mask);
          res |= (la * lb) << (64 - (2*k + 2) * w);
        end
        return res;
      end
      6'd6, 6'd7, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15, 6'd18: begin
        for (int i = 0; i < n; i++) begin
          pos = 64 - (i + 1) * w;
          la = (a >> pos) & mask;
          lb = (b >> pos) & mask;
          s = int'(lb) & (w - 1);
          case (f)
            6'd6:  r = la + lb;
            6'd7:  r = la - lb;
            6'd10: r = la << s;
            6'd11: r = la >> s;
            6'd12: begin
              r = la >> s;
              if (la[w-1] && s > 0) r |= mask & ~(mask >> s);
            end
            6'd13: r = (la << (w/2)) | (la >> (w/2));
            6'd14: r = (lb == 0) ? mask : la / lb;
            6'd15: r = (lb == 0) ? la : la % lb;
            default: r = intSqrt(la);
          endcase
          res |= (r & mask) << pos;
        end
        return res;
      end
      default: return 0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] expected);
    assertCount++;
    assert (aluOut === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, aluOut, expected);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] f,
                               input logic [1:0] wsel, input logic [63:0] a,
                               input logic [63:0] b);
    opCode = op;
    rIns = f;
    ww = wsel;
    aVal = a;
    bVal = b;
    @(posedge clk);
    #1;
  endtask

  task automatic runOp(input string tag, input logic [5:0] f, input logic [1:0] wsel,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] expected);
    applyStimulus(RTYPE, f, wsel, a, b);
    checkOutput(tag, expected);
  endtask

  initial begin
    logic [63:0] ra, rb, bmask;
    logic [5:0]  rf, rop;
    logic [1:0]  rw;

    reset = 1'b1;
    opCode = RTYPE;
    rIns = 6'd1;
    ww = 2'b10;
    aVal = 64'd15;
    bVal = 64'd14;
    #12;
    checkOutput("resetInit", 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("firstAfterReset", 64'd14);

    runOp("vand", 6'd1, 2'b10, 64'd15, 64'd14, 64'd14);
    runOp("vor",  6'd2, 2'b10, 64'd15, 64'd14, 64'd15);
    runOp("vxor", 6'd3, 2'b10, 64'd15, 64'd14, 64'd1);
    runOp("vnot", 6'd4, 2'b00, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    runOp("vadd32", 6'd6, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_1111_1111,
          64'hFFFF_FFFF_1111_1110);
    runOp("vsub64", 6'd7, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_1111_1111,
          64'hFFFF_FFFF_EEEE_EEEE);
    runOp("vmuleu16", 6'd8, 2'b01, 64'hFF00_0000_FFFF_FFFF, 64'h0002_0000_000F_0001,
          64'h0001_FE00_000E_FFF1);
    runOp("vmulou16", 6'd9, 2'b01, 64'hFF00_0000_FFFF_FFFF, 64'h0002_0000_000F_0001,
          64'h0000_0000_0000_FFFF);
    runOp("vmuleu32", 6'd8, 2'b10, 64'h20, 64'h20, 64'h0);
    runOp("vmulou32", 6'd9, 2'b10, 64'h20, 64'h20, 64'h400);
    runOp("vmul64zero", 6'd8, 2'b11, 64'h1234, 64'h5678, 64'h0);
    runOp("vdiv8", 6'd14, 2'b00, 64'hFF00_FF00_FF00_FF00, 64'h1122_1122_4444_4444,
          64'h0F00_0F00_0300_0300);
    runOp("vmod64", 6'd15, 2'b11, 64'd102, 64'd10, 64'd2);
    runOp("vdivZero", 6'd14, 2'b00, 64'h1234_5678_9ABC_DEF0, 64'h0,
          64'hFFFF_FFFF_FFFF_FFFF);
    runOp("vmodZero", 6'd15, 2'b01, 64'h1234_5678_9ABC_DEF0, 64'h0,
          64'h1234_5678_9ABC_DEF0);
    runOp("vrtth64", 6'd13, 2'b11, 64'hFFFF_FFFF_0000_0000, 64'h0, 64'h0000_0000_FFFF_FFFF);
    runOp("vsqeu32", 6'd16, 2'b10, 64'h0000_0040_0000_0001, 64'h0, 64'h0000_0000_0000_1000);
    runOp("vsqou32", 6'd17, 2'b10, 64'h0000_0040_0000_0001, 64'h0, 64'h1);
    runOp("vsqrt32", 6'd18, 2'b10, 64'h0000_0040_0000_0001, 64'h0, 64'h0000_0008_0000_0001);
    runOp("vsra8", 6'd12, 2'b00, 64'h8040_F000_0000_0000, 64'h0301_0400_0000_0000,
          64'hF020_FF00_0000_0000);
    runOp("unlisted", 6'd0, 2'b00, 64'hFFFF, 64'hFFFF, 64'h0);
    applyStimulus(6'd0, 6'd5, 2'b00, 64'hABCD, 64'h0);
    checkOutput("notRtype", 64'h0);

    // Async reset in mid-cycle discards the op that would have been captured
    applyStimulus(RTYPE, 6'd2, 2'b00, 64'hF0, 64'h0F);
    checkOutput("preResetOp", 64'hFF);
    aVal = 64'hF0;
    bVal = 64'h33;
    rIns = 6'd3;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("resetAsync", 64'h0);
    @(posedge clk);
    #1;
    checkOutput("resetHeld", 64'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("resetRelease", 64'hC3);

    for (int i = 0; i < 400; i++) begin
      rf = opList[$urandom_range(0, 18)];
      rop = ($urandom_range(0, 19) == 0) ? 6'($urandom) : RTYPE;
      rw = 2'($urandom);
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      bmask = 64'hFFFF_FFFF_FFFF_FFFF;
      for (int k = 0; k < 8; k++)
        if ($urandom_range(0, 3) == 0) bmask[k*8 +: 8] = 8'h00;
      rb &= bmask;
      applyStimulus(rop, rf, rw, ra, rb);
      checkOutput($sformatf("rand%0d_f%0d_w%0d", i, rf, rw), refModel(rop, rf, rw, ra, rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
